// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared constants for the multi-port register file and its users.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  // Default datapath sizing, shared with decode and writeback.
  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_ADDR_W = 5;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_clear_seq.sv
// ============================================================================
// Module : regfile_clear_seq
// Brief  : CLEAR/RUN sequencer that walks every entry once, writing zero.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] C_LAST = '1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          // The counter is parked at zero on exit so it never wraps.
          if (r_clr_cnt == C_LAST) begin
            r_state   <= ST_RUN;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (clear) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        default: begin
          r_state   <= ST_CLEAR;
          r_clr_cnt <= '0;
        end
      endcase
    end
  end

  assign ready    = (r_state == ST_RUN);
  assign clr_we   = (r_state == ST_CLEAR);
  assign clr_addr = r_clr_cnt;

endmodule : regfile_clear_seq

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module : regfile_mp
// Brief  : Two-write/two-read register file with hardwired zero and a
//          sequenced clear. Define REGFILE_BYPASS_EN for same-cycle
//          write-to-read forwarding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              ready,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wok0;
  logic              w_wok1;
  logic              w_rok0;
  logic              w_rok1;
  logic              w_we0;
  logic              w_we1;
  logic [DATA_W-1:0] w_rd0;
  logic [DATA_W-1:0] w_rd1;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .ready    (ready),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  generate
    if (ZERO_REG != 0) begin : g_zero_reg
      assign w_wok0 = (waddr0 != '0);
      assign w_wok1 = (waddr1 != '0);
      assign w_rok0 = (raddr0 != '0);
      assign w_rok1 = (raddr1 != '0);
    end else begin : g_plain_reg
      assign w_wok0 = 1'b1;
      assign w_wok1 = 1'b1;
      assign w_rok0 = 1'b1;
      assign w_rok1 = 1'b1;
    end
  endgenerate

  // ready is cleared asynchronously, so a write racing reset never commits.
  assign w_we0 = we0 & ready & w_wok0;
  assign w_we1 = we1 & ready & w_wok1;

  // Lane 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (w_clr_we && rst_n) begin
      r_mem[w_clr_addr] <= '0;
    end else begin
      if (w_we0) r_mem[waddr0] <= wdata0;
      if (w_we1) r_mem[waddr1] <= wdata1;
    end
  end

  always_comb begin
    w_rd0 = r_mem[raddr0];
`ifdef REGFILE_BYPASS_EN
    if (w_we0 && (waddr0 == raddr0)) w_rd0 = wdata0;
    if (w_we1 && (waddr1 == raddr0)) w_rd0 = wdata1;
`endif
  end

  always_comb begin
    w_rd1 = r_mem[raddr1];
`ifdef REGFILE_BYPASS_EN
    if (w_we0 && (waddr0 == raddr1)) w_rd1 = wdata0;
    if (w_we1 && (waddr1 == raddr1)) w_rd1 = wdata1;
`endif
  end

  assign rdata0 = (ready && w_rok0) ? w_rd0 : '0;
  assign rdata1 = (ready && w_rok1) ? w_rd1 : '0;

endmodule : regfile_mp

`default_nettype wire
